// File: rtl/err_metric_acc_pkg.sv
// Shared types and width helpers for the approximate-circuit error evaluation blocks.
package err_eval_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_W         = 3;
    localparam int DEF_N_SAMPLES = 16;

    // A run of at most 2**cnt_w - 1 samples, each contributing < 2**w, cannot overflow w + cnt_w bits.
    function automatic int sum_acc_width(input int w, input int cnt_w);
        return w + cnt_w;
    endfunction

    function automatic int sq_acc_width(input int w, input int cnt_w);
        return 2 * w + cnt_w;
    endfunction

endpackage

// File: rtl/err_metric_acc_abs_err_calc.sv
// Combinational absolute difference between an exact and an approximate result word.
module abs_err_calc
    import err_eval_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] exact_val,
    input  logic [W-1:0] approx_val,
    output logic [W-1:0] d,
    output logic         nonzero
);

    logic [W:0] exact_ext;
    logic [W:0] approx_ext;
    logic [W:0] diff;

    assign exact_ext  = {1'b0, exact_val};
    assign approx_ext = {1'b0, approx_val};

    always_comb begin
        diff = '0;
        if (exact_ext >= approx_ext) begin
            diff = exact_ext - approx_ext;
        end else begin
            diff = approx_ext - exact_ext;
        end
    end

    // The magnitude always fits in W bits; the extra bit only carries the subtraction.
    assign d       = diff[W-1:0];
    assign nonzero = |diff;

endmodule

// File: rtl/err_metric_acc.sv
// Accumulates error metrics (count, max, sum, optional sum of squares) over a fixed run of samples.
// Define ERR_METRIC_SQ_EN to add the sum_sq_err output and its multiplier.
module err_metric_acc
    import err_eval_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int N_SAMPLES = DEF_N_SAMPLES,
    parameter int CNT_W     = $clog2(N_SAMPLES + 1)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                sample_valid,
    output logic                                sample_ready,
    input  logic [W-1:0]                        exact_val,
    input  logic [W-1:0]                        approx_val,
    output logic                                busy,
    output logic                                done,
    output logic [CNT_W-1:0]                    sample_cnt,
    output logic [CNT_W-1:0]                    err_cnt,
    output logic [W-1:0]                        max_abs_err,
    output logic [sum_acc_width(W, CNT_W)-1:0]  sum_abs_err
`ifdef ERR_METRIC_SQ_EN
    ,
    output logic [sq_acc_width(W, CNT_W)-1:0]   sum_sq_err
`endif
);

    localparam int SUM_W = sum_acc_width(W, CNT_W);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

    state_t         state;
    state_t         state_nxt;
    logic           accept;
    logic           clear;
    logic           last_sample;
    logic [W-1:0]   d;
    logic           nonzero;

    abs_err_calc #(
        .W (W)
    ) u_abs_err_calc (
        .exact_val  (exact_val),
        .approx_val (approx_val),
        .d          (d),
        .nonzero    (nonzero)
    );

    assign sample_ready = (state == RUN);
    assign busy         = (state == RUN);
    assign done         = (state == DONE);

    // A start in the same cycle as a sample wins: ready is low outside RUN, so nothing is accepted.
    assign accept      = sample_valid && sample_ready;
    assign clear       = start && (state != RUN);
    assign last_sample = (sample_cnt == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (accept && last_sample) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt  <= '0;
            err_cnt     <= '0;
            max_abs_err <= '0;
            sum_abs_err <= '0;
        end else if (clear) begin
            sample_cnt  <= '0;
            err_cnt     <= '0;
            max_abs_err <= '0;
            sum_abs_err <= '0;
        end else if (accept) begin
            sample_cnt  <= sample_cnt + 1'b1;
            err_cnt     <= err_cnt + CNT_W'(nonzero);
            sum_abs_err <= sum_abs_err + SUM_W'(d);
            if (d > max_abs_err) begin
                max_abs_err <= d;
            end
        end
    end

`ifdef ERR_METRIC_SQ_EN
    localparam int SQ_W  = sq_acc_width(W, CNT_W);
    localparam int SQP_W = 2 * W;

    logic [SQP_W-1:0] d_sq;

    assign d_sq = SQP_W'(d) * SQP_W'(d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_sq_err <= '0;
        end else if (clear) begin
            sum_sq_err <= '0;
        end else if (accept) begin
            sum_sq_err <= sum_sq_err + SQ_W'(d_sq);
        end
    end
`endif

endmodule

// File: tb/tb_err_metric_acc.sv
// Self-checking bench for err_metric_acc: a 16-sample and a 4-sample instance against a queue-based model.
module tb_err_metric_acc;

    localparam int W  = 3;
    localparam int NA = 16;
    localparam int NB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start;
    logic         sample_valid;
    logic [W-1:0] exact_val;
    logic [W-1:0] approx_val;
    int           sel;

    logic       a_start, a_valid, a_ready, a_busy, a_done;
    logic [4:0] a_cnt, a_err;
    logic [2:0] a_max;
    logic [7:0] a_sum;
    logic       b_start, b_valid, b_ready, b_busy, b_done;
    logic [2:0] b_cnt, b_err;
    logic [2:0] b_max;
    logic [5:0] b_sum;

    logic       o_ready, o_busy, o_done;
    logic [4:0] o_cnt, o_err;
    logic [2:0] o_max;
    logic [7:0] o_sum;
`ifdef ERR_METRIC_SQ_EN
    logic [10:0] a_sq;
    logic [8:0]  b_sq;
    logic [10:0] o_sq;
`endif

    assign a_start = start && (sel == 0);
    assign a_valid = sample_valid && (sel == 0);
    assign b_start = start && (sel == 1);
    assign b_valid = sample_valid && (sel == 1);

    always_comb begin
        o_ready = (sel == 0) ? a_ready : b_ready;
        o_busy  = (sel == 0) ? a_busy  : b_busy;
        o_done  = (sel == 0) ? a_done  : b_done;
        o_cnt   = (sel == 0) ? a_cnt   : {2'b00, b_cnt};
        o_err   = (sel == 0) ? a_err   : {2'b00, b_err};
        o_max   = (sel == 0) ? a_max   : b_max;
        o_sum   = (sel == 0) ? a_sum   : {2'b00, b_sum};
`ifdef ERR_METRIC_SQ_EN
        o_sq    = (sel == 0) ? a_sq    : {2'b00, b_sq};
`endif
    end

    err_metric_acc #(.W(W), .N_SAMPLES(NA)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .sample_valid(a_valid),
        .sample_ready(a_ready), .exact_val(exact_val), .approx_val(approx_val),
        .busy(a_busy), .done(a_done), .sample_cnt(a_cnt), .err_cnt(a_err),
        .max_abs_err(a_max), .sum_abs_err(a_sum)
`ifdef ERR_METRIC_SQ_EN
        , .sum_sq_err(a_sq)
`endif
    );

    err_metric_acc #(.W(W), .N_SAMPLES(NB)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .sample_valid(b_valid),
        .sample_ready(b_ready), .exact_val(exact_val), .approx_val(approx_val),
        .busy(b_busy), .done(b_done), .sample_cnt(b_cnt), .err_cnt(b_err),
        .max_abs_err(b_max), .sum_abs_err(b_sum)
`ifdef ERR_METRIC_SQ_EN
        , .sum_sq_err(b_sq)
`endif
    );

    // Reference model: the list of |d| accepted so far in the current run.
    int q[$];
    bit m_run;
    bit m_fin;
    int total;
    int bad;

    function automatic int abs_diff(input int e, input int a);
        return (e > a) ? e - a : a - e;
    endfunction

    function automatic int n_cur();
        return (sel == 0) ? NA : NB;
    endfunction

    function automatic int m_sum();
        int s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    function automatic int m_err();
        int s = 0;
        foreach (q[i]) if (q[i] != 0) s++;
        return s;
    endfunction

    function automatic int m_max();
        int s = 0;
        foreach (q[i]) if (q[i] > s) s = q[i];
        return s;
    endfunction

    function automatic int m_sq();
        int s = 0;
        foreach (q[i]) s += q[i] * q[i];
        return s;
    endfunction

    task automatic model_reset();
        q.delete();
        m_run = 1'b0;
        m_fin = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        if (start && !m_run) begin
            q.delete();
            m_run = 1'b1;
            m_fin = 1'b0;
        end else if (m_run && sample_valid) begin
            q.push_back(abs_diff(int'(exact_val), int'(approx_val)));
            if (q.size() == n_cur()) begin
                m_run = 1'b0;
                m_fin = 1'b1;
            end
        end
        #1;
    endtask

    task automatic select(input int s);
        sel = s;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        sample_valid = 1'b0;
        exact_val = '0;
        approx_val = '0;
        select(0);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({a_ready, a_busy, a_done, a_cnt, a_err, a_max, a_sum} !== '0) begin
            bad++;
            $display("FAIL reset_a: got rdy=%b busy=%b done=%b cnt=%0d err=%0d max=%0d sum=%0d want all 0",
                     a_ready, a_busy, a_done, a_cnt, a_err, a_max, a_sum);
        end
        total++;
        if ({b_ready, b_busy, b_done, b_cnt, b_err, b_max, b_sum} !== '0) begin
            bad++;
            $display("FAIL reset_b: got rdy=%b busy=%b done=%b cnt=%0d want all 0", b_ready, b_busy, b_done, b_cnt);
        end
`ifdef ERR_METRIC_SQ_EN
        total++;
        if (a_sq !== '0 || b_sq !== '0) begin
            bad++;
            $display("FAIL reset_sq: got a=%0d b=%0d want 0", a_sq, b_sq);
        end
`endif
        rst_n = 1'b1;
        sample_valid = 1'b1;
        exact_val = 3'd5;
        approx_val = 3'd1;
        repeat (3) step();
        total++;
        if (o_cnt !== 5'd0 || o_sum !== 8'd0 || o_ready !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_valid: got cnt=%0d sum=%0d rdy=%b busy=%b want 0 0 0 0", o_cnt, o_sum, o_ready, o_busy);
        end
        sample_valid = 1'b0;
    endtask

    task automatic test_exact_match();
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (o_busy !== 1'b1 || o_ready !== 1'b1 || o_cnt !== 5'd0) begin
            bad++;
            $display("FAIL exact_start: got busy=%b rdy=%b cnt=%0d want 1 1 0", o_busy, o_ready, o_cnt);
        end
        sample_valid = 1'b1;
        exact_val = 3'b010;
        approx_val = 3'b010;
        for (int i = 0; i < NA; i++) begin
            step();
            total++;
            if (o_done !== m_fin || o_cnt !== 5'(q.size())) begin
                bad++;
                $display("FAIL exact_step%0d: got done=%b cnt=%0d want %b %0d", i, o_done, o_cnt, m_fin, q.size());
            end
        end
        sample_valid = 1'b0;
        total++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_cnt !== 5'd16 || o_err !== 5'd0 ||
            o_max !== 3'd0 || o_sum !== 8'd0) begin
            bad++;
            $display("FAIL exact_final: got done=%b busy=%b cnt=%0d err=%0d max=%0d sum=%0d want 1 0 16 0 0 0",
                     o_done, o_busy, o_cnt, o_err, o_max, o_sum);
        end
        repeat (3) step();
        total++;
        if (o_done !== 1'b1 || o_cnt !== 5'd16) begin
            bad++;
            $display("FAIL exact_hold: got done=%b cnt=%0d want 1 16", o_done, o_cnt);
        end
    endtask

    task automatic test_gaps();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 80 && !m_fin; i++) begin
            sample_valid = (i % 2 == 0);
            start = (i == 6);
            exact_val = W'($urandom);
            approx_val = W'($urandom);
            step();
            total++;
            if (o_cnt !== 5'(q.size()) || o_sum !== 8'(m_sum()) || o_busy !== m_run) begin
                bad++;
                $display("FAIL gaps_step%0d: got cnt=%0d sum=%0d busy=%b want %0d %0d %b",
                         i, o_cnt, o_sum, o_busy, q.size(), m_sum(), m_run);
            end
        end
        start = 1'b0;
        sample_valid = 1'b0;
        total++;
        if (o_done !== 1'b1 || o_cnt !== 5'd16 || o_err !== 5'(m_err()) || o_max !== 3'(m_max())) begin
            bad++;
            $display("FAIL gaps_final: got done=%b cnt=%0d err=%0d max=%0d want 1 16 %0d %0d",
                     o_done, o_cnt, o_err, o_max, m_err(), m_max());
        end
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 3; r++) begin
            start = 1'b1;
            step();
            start = 1'b0;
            for (int i = 0; i < 200 && !m_fin; i++) begin
                sample_valid = 1'($urandom_range(0, 1));
                exact_val = W'($urandom);
                approx_val = W'($urandom);
                step();
                total++;
                if (o_cnt !== 5'(q.size()) || o_err !== 5'(m_err()) || o_sum !== 8'(m_sum()) ||
                    o_max !== 3'(m_max()) || o_done !== m_fin) begin
                    bad++;
                    $display("FAIL rand%0d_step%0d: got cnt=%0d err=%0d sum=%0d max=%0d done=%b want %0d %0d %0d %0d %b",
                             r, i, o_cnt, o_err, o_sum, o_max, o_done, q.size(), m_err(), m_sum(), m_max(), m_fin);
                end
`ifdef ERR_METRIC_SQ_EN
                total++;
                if (o_sq !== 11'(m_sq())) begin
                    bad++;
                    $display("FAIL rand%0d_sq: got %0d want %0d", r, o_sq, m_sq());
                end
`endif
            end
            sample_valid = 1'b0;
            total++;
            if (o_done !== 1'b1) begin
                bad++;
                $display("FAIL rand%0d_done: got %b want 1", r, o_done);
            end
        end
    endtask

    task automatic test_mixed();
        int ex[4] = '{3, 0, 1, 3};
        int ap[4] = '{1, 2, 1, 0};
        select(1);
        start = 1'b1;
        sample_valid = 1'b1;
        exact_val = 3'd7;
        approx_val = 3'd0;
        step();
        start = 1'b0;
        total++;
        if (o_cnt !== 5'd0 || o_max !== 3'd0 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL mixed_start_sample: got cnt=%0d max=%0d busy=%b want 0 0 1", o_cnt, o_max, o_busy);
        end
        for (int i = 0; i < 4; i++) begin
            exact_val = W'(ex[i]);
            approx_val = W'(ap[i]);
            step();
        end
        sample_valid = 1'b0;
        total++;
        if (o_done !== 1'b1 || o_cnt !== 5'd4 || o_err !== 5'd3 || o_max !== 3'd3 || o_sum !== 8'd7) begin
            bad++;
            $display("FAIL mixed_final: got done=%b cnt=%0d err=%0d max=%0d sum=%0d want 1 4 3 3 7",
                     o_done, o_cnt, o_err, o_max, o_sum);
        end
        total++;
        if (o_err !== 5'(m_err()) || o_sum !== 8'(m_sum())) begin
            bad++;
            $display("FAIL mixed_model: got err=%0d sum=%0d want %0d %0d", o_err, o_sum, m_err(), m_sum());
        end
`ifdef ERR_METRIC_SQ_EN
        total++;
        if (o_sq !== 11'd17) begin
            bad++;
            $display("FAIL mixed_sq: got %0d want 17", o_sq);
        end
`endif
    endtask

    task automatic test_restart();
        start = 1'b1;
        sample_valid = 1'b1;
        exact_val = 3'd5;
        approx_val = 3'd1;
        step();
        start = 1'b0;
        total++;
        if (o_cnt !== 5'd0 || o_err !== 5'd0 || o_sum !== 8'd0 || o_max !== 3'd0 ||
            o_busy !== 1'b1 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL restart_clear: got cnt=%0d err=%0d sum=%0d max=%0d busy=%b done=%b want 0 0 0 0 1 0",
                     o_cnt, o_err, o_sum, o_max, o_busy, o_done);
        end
        for (int i = 0; i < 4; i++) begin
            exact_val = W'($urandom);
            approx_val = exact_val;
            step();
        end
        sample_valid = 1'b0;
        total++;
        if (o_done !== 1'b1 || o_cnt !== 5'd4 || o_err !== 5'd0 || o_sum !== 8'd0) begin
            bad++;
            $display("FAIL restart_final: got done=%b cnt=%0d err=%0d sum=%0d want 1 4 0 0", o_done, o_cnt, o_err, o_sum);
        end
    endtask

    task automatic test_reset_mid_run();
        select(0);
        start = 1'b1;
        step();
        start = 1'b0;
        sample_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exact_val = W'($urandom);
            approx_val = W'($urandom);
            step();
        end
        sample_valid = 1'b0;
        total++;
        if (o_cnt !== 5'd5) begin
            bad++;
            $display("FAIL midrst_pre: got cnt=%0d want 5", o_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({a_ready, a_busy, a_done, a_cnt, a_err, a_max, a_sum} !== '0) begin
            bad++;
            $display("FAIL midrst_async: got busy=%b cnt=%0d err=%0d sum=%0d want all 0", a_busy, a_cnt, a_err, a_sum);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 200 && !m_fin; i++) begin
            sample_valid = 1'($urandom_range(0, 1));
            exact_val = W'($urandom);
            approx_val = W'($urandom);
            step();
        end
        sample_valid = 1'b0;
        total++;
        if (o_done !== 1'b1 || o_cnt !== 5'd16 || o_err !== 5'(m_err()) ||
            o_sum !== 8'(m_sum()) || o_max !== 3'(m_max())) begin
            bad++;
            $display("FAIL midrst_rerun: got done=%b cnt=%0d err=%0d sum=%0d max=%0d want 1 16 %0d %0d %0d",
                     o_done, o_cnt, o_err, o_sum, o_max, m_err(), m_sum(), m_max());
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_exact_match();
        test_gaps();
        test_random_runs();
        test_mixed();
        test_restart();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/err_metric_acc.md
Name: err_metric_acc

Overview:
- Downstream consumer of a combinational approximate circuit under evaluation (e.g. a 2-bit absolute-difference unit) and of its exact golden model.
- Per accepted sample, compares the approximate output with the exact output and accumulates error metrics over a fixed-length run of N_SAMPLES.
- Presents the metrics with a done flag for the evaluation harness.

Parameters:
- W, 3, width of the exact and approximate result words.
- N_SAMPLES, 16, number of samples per run; must be at least 1.
- CNT_W, $clog2(N_SAMPLES+1), width of the sample and error counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle run request.
- sample_valid  in  1  sample present on exact_val/approx_val.
- sample_ready  out  1  block accepts a sample this cycle.
- exact_val  in  W  golden result.
- approx_val  in  W  approximate result.
- busy  out  1  run in progress.
- done  out  1  run complete; metrics stable.
- sample_cnt  out  CNT_W  samples accepted this run.
- err_cnt  out  CNT_W  samples with exact_val != approx_val.
- max_abs_err  out  W  maximum |exact_val - approx_val|.
- sum_abs_err  out  W+CNT_W  sum of |exact_val - approx_val|.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - State enters IDLE.
  - All outputs are 0; sample_ready is 0.
- States: IDLE, RUN, DONE.
  - IDLE: start moves to RUN next cycle and clears all accumulators in the same edge.
  - RUN: busy=1 and sample_ready=1. The state moves to DONE on the edge that accepts sample number N_SAMPLES.
  - DONE: done=1 and busy=0. start clears the accumulators and returns to RUN. Otherwise DONE holds indefinitely.
- Accept: a sample is accepted on a rising edge when sample_valid && sample_ready. Inputs are sampled only then; sample_valid outside RUN is ignored.
- Per accepted sample, registered at that edge:
  - d = |exact_val - approx_val|, computed unsigned in W+1 bits and result W bits.
  - sample_cnt += 1.
  - err_cnt += (d != 0).
  - sum_abs_err += d.
  - max_abs_err = max(max_abs_err, d).
- Latency: metrics reflect a sample one cycle after its accept edge. done rises in the cycle after the final accept edge, with metrics already final.
- Widths: accumulators are sized so no overflow is possible for N_SAMPLES samples. No saturation logic is required.
- start while in RUN is ignored and the run continues.
- start with sample_valid in the same IDLE/DONE cycle: start is honoured; the sample is not accepted (sample_ready=0 that cycle).
- N_SAMPLES=1: RUN lasts exactly one accept.
- rst_n asserted mid-run: immediate return to IDLE, all outputs 0, partial results discarded.

Optional Feature:
- Macro ERR_METRIC_SQ_EN.
- Defined:
  - Adds output sum_sq_err, width 2*W+CNT_W, accumulating d*d per accepted sample.
  - Same timing, clearing and reset rules as sum_abs_err.
- Undefined: the port and its multiplier are absent; all other behaviour is identical.

Decomposition:
- Package err_eval_pkg:
  - state enum (IDLE, RUN, DONE).
  - Default width localparams.
  - Function for the sum-accumulator width.
- Sub-module abs_err_calc: purely combinational. Inputs exact_val and approx_val; outputs d and a nonzero flag. Reused by sibling metric blocks.

Test Plan:
- Reset then idle: rst_n low 2 cycles, no start -> all outputs 0, sample_ready=0, busy=0, done=0; sample_valid=1 in IDLE has no effect.
- Exact match run: start, 16 samples with exact_val=approx_val=3'b010 -> done=1 one cycle after the 16th accept; sample_cnt=16, err_cnt=0, max_abs_err=0, sum_abs_err=0.
- Mixed errors, N_SAMPLES=4: (exact,approx) = (3,1), (0,2), (1,1), (3,0) -> err_cnt=3, max_abs_err=3, sum_abs_err=7; with ERR_METRIC_SQ_EN, sum_sq_err=17.
- Valid gaps and ignored start: sample_valid toggled every other cycle, start pulsed mid-run -> sample_cnt counts only valid cycles; the run is not restarted.
- Restart from DONE: after the mixed run, start plus 4 zero-error samples -> metrics cleared at the start edge; final err_cnt=0, sample_cnt=4.
- Reset mid-run: rst_n low after 5 accepts -> outputs 0 asynchronously; a subsequent full run gives correct counts from zero.
